serial_compare_ctrl: RTL and testbench

- Sequencer that compares two WIDTH-bit unsigned operands using the existing 2-bit greater-than gate-level slice.
- Walks the operands MSB-first, one 2-bit slice per clock, and terminates early at the first differing slice.
- Reports greater-than and equal flags with a valid/ready start and a done pulse.
- Sits between operand producers and downstream logic that needs wide magnitude compares without a wide combinational comparator.

---
 rtl/comparator_pkg.sv | 13 +
 rtl/greater_than_2_bit.sv | 11 +
 rtl/serial_compare_ctrl.sv | 131 +++++++++++++
 tb/tb_serial_compare_ctrl.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/comparator_pkg.sv
// Shared state encoding and slice geometry for the serial magnitude comparator.
// Pure types and constants; no logic, no latency, no flow control.
package comparator_pkg;

    typedef enum logic [1:0] {
        IDLE,
        COMPARE,
        DONE
    } cmp_state_t;

    localparam int SLICE_W = 2;

endpackage

// File: rtl/greater_than_2_bit.sv
// Gate-level 2-bit unsigned greater-than slice: gt = (a > b).
// Purely combinational, zero latency, no flow control.
module greater_than_2_bit (
    input  logic [1:0] a,
    input  logic [1:0] b,
    output logic       gt
);

    assign gt = (a[1] & ~b[1]) | (~(a[1] ^ b[1]) & a[0] & ~b[0]);

endmodule

// File: rtl/serial_compare_ctrl.sv
// MSB-first serial magnitude compare of two WIDTH-bit operands, one 2-bit slice per cycle.
// Latency k+1 cycles to done (k = first differing slice); start is only accepted while in_ready.
module serial_compare_ctrl
    import comparator_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             in_ready,
    output logic             busy,
    output logic             done,
    output logic             gt,
    output logic             eq
);

    localparam int NUM_SLICES = WIDTH / SLICE_W;
    localparam int CNT_W      = (NUM_SLICES > 1) ? $clog2(NUM_SLICES) : 1;

    cmp_state_t       state_q, state_d;
    logic [WIDTH-1:0] sa_q, sa_d;
    logic [WIDTH-1:0] sb_q, sb_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             gt_q, gt_d;
    logic             eq_q, eq_d;
    logic             done_q, done_d;
    logic             busy_q, busy_d;
    logic             in_ready_q, in_ready_d;

    logic             s_gt;
    logic             s_lt;

    // Same slice instantiated twice with swapped operands gives both orderings.
    greater_than_2_bit u_slice_gt (
        .a  (sa_q[WIDTH-1 -: SLICE_W]),
        .b  (sb_q[WIDTH-1 -: SLICE_W]),
        .gt (s_gt)
    );

    greater_than_2_bit u_slice_lt (
        .a  (sb_q[WIDTH-1 -: SLICE_W]),
        .b  (sa_q[WIDTH-1 -: SLICE_W]),
        .gt (s_lt)
    );

    always_comb begin
        state_d = state_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        cnt_d   = cnt_q;
        gt_d    = gt_q;
        eq_d    = eq_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    sa_d    = a;
                    sb_d    = b;
                    cnt_d   = CNT_W'(NUM_SLICES - 1);
                    gt_d    = 1'b0;
                    eq_d    = 1'b0;
                    state_d = COMPARE;
                end
            end
            COMPARE: begin
                if (s_gt) begin
                    gt_d    = 1'b1;
                    eq_d    = 1'b0;
                    state_d = DONE;
                end else if (s_lt) begin
                    gt_d    = 1'b0;
                    eq_d    = 1'b0;
                    state_d = DONE;
                end else if (cnt_q == '0) begin
                    gt_d    = 1'b0;
                    eq_d    = 1'b1;
                    state_d = DONE;
                end else begin
                    sa_d  = sa_q << SLICE_W;
                    sb_d  = sb_q << SLICE_W;
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Status outputs are registered from the next state so they align with state_q.
        done_d     = (state_d == DONE);
        busy_d     = (state_d != IDLE);
        in_ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            sa_q       <= '0;
            sb_q       <= '0;
            cnt_q      <= '0;
            gt_q       <= 1'b0;
            eq_q       <= 1'b0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            sa_q       <= sa_d;
            sb_q       <= sb_d;
            cnt_q      <= cnt_d;
            gt_q       <= gt_d;
            eq_q       <= eq_d;
            done_q     <= done_d;
            busy_q     <= busy_d;
            in_ready_q <= in_ready_d;
        end
    end

    assign in_ready = in_ready_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign gt       = gt_q;
    assign eq       = eq_q;

endmodule

// File: tb/tb_serial_compare_ctrl.sv
// Directed bench for serial_compare_ctrl: 8-bit scenarios plus an exhaustive 4-bit sweep.
module tb_serial_compare_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       start8, start4;
    logic [7:0] a8, b8;
    logic [3:0] a4, b4;
    logic       in_ready8, busy8, done8, gt8, eq8;
    logic       in_ready4, busy4, done4, gt4, eq4;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    serial_compare_ctrl #(.WIDTH(8)) dut8 (
        .clk      (clk),
        .rst      (rst),
        .start    (start8),
        .a        (a8),
        .b        (b8),
        .in_ready (in_ready8),
        .busy     (busy8),
        .done     (done8),
        .gt       (gt8),
        .eq       (eq8)
    );

    serial_compare_ctrl #(.WIDTH(4)) dut4 (
        .clk      (clk),
        .rst      (rst),
        .start    (start4),
        .a        (a4),
        .b        (b4),
        .in_ready (in_ready4),
        .busy     (busy4),
        .done     (done4),
        .gt       (gt4),
        .eq       (eq4)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input int obs, input int exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Issue one 8-bit compare; exp_lat counts cycles from acceptance to the done cycle (k+1).
    task automatic run8(input string tag, input logic [7:0] va, input logic [7:0] vb,
                        input int exp_lat, input int exp_gt, input int exp_eq,
                        input bit keep_start, input logic [7:0] na, input logic [7:0] nb);
        int n;
        int busy_cnt;
        a8     = va;
        b8     = vb;
        start8 = 1'b1;
        check({tag, ".in_ready_pre"}, int'(in_ready8), 1);
        step();
        if (keep_start) begin
            a8 = na;
            b8 = nb;
        end else begin
            start8 = 1'b0;
        end
        check({tag, ".gt_cleared"}, int'(gt8), 0);
        check({tag, ".eq_cleared"}, int'(eq8), 0);
        check({tag, ".in_ready_busy"}, int'(in_ready8), 0);
        n        = 1;
        busy_cnt = int'(busy8);
        while (!done8 && n < 20) begin
            step();
            n++;
            busy_cnt += int'(busy8);
        end
        check({tag, ".latency"}, n, exp_lat);
        check({tag, ".busy_cycles"}, busy_cnt, exp_lat);
        check({tag, ".gt"}, int'(gt8), exp_gt);
        check({tag, ".eq"}, int'(eq8), exp_eq);
        step();
        check({tag, ".done_pulse"}, int'(done8), 0);
        check({tag, ".idle_ready"}, int'(in_ready8), 1);
        check({tag, ".gt_hold"}, int'(gt8), exp_gt);
    endtask

    initial begin
        rst    = 1'b1;
        start8 = 1'b0;
        start4 = 1'b0;
        a8     = '0;
        b8     = '0;
        a4     = '0;
        b4     = '0;
        step();
        step();
        rst = 1'b0;
        check("reset.in_ready", int'(in_ready8), 1);
        check("reset.busy", int'(busy8), 0);
        check("reset.done", int'(done8), 0);
        check("reset.gt", int'(gt8), 0);
        check("reset.eq", int'(eq8), 0);

        run8("c0_40", 8'hC0, 8'h40, 2, 1, 0, 1'b0, 8'h00, 8'h00);
        run8("12_13", 8'h12, 8'h13, 5, 0, 0, 1'b0, 8'h00, 8'h00);
        run8("a5_a5", 8'hA5, 8'hA5, 5, 0, 1, 1'b0, 8'h00, 8'h00);
        run8("ff_00", 8'hFF, 8'h00, 2, 1, 0, 1'b0, 8'h00, 8'h00);

        // Start held high through a busy window must not be queued.
        run8("01_02", 8'h01, 8'h02, 5, 0, 0, 1'b1, 8'hFF, 8'h00);
        run8("held_ff_00", 8'hFF, 8'h00, 2, 1, 0, 1'b0, 8'h00, 8'h00);

        // Reset during the second COMPARE cycle aborts without a done pulse.
        a8     = 8'h3C;
        b8     = 8'h3C;
        start8 = 1'b1;
        step();
        start8 = 1'b0;
        step();
        check("abort.busy_before", int'(busy8), 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("abort.done", int'(done8), 0);
        check("abort.gt", int'(gt8), 0);
        check("abort.eq", int'(eq8), 0);
        check("abort.in_ready", int'(in_ready8), 1);
        check("abort.busy", int'(busy8), 0);
        for (int i = 0; i < 4; i++) begin
            step();
            check("abort.no_done", int'(done8), 0);
        end
        run8("80_7f", 8'h80, 8'h7F, 2, 1, 0, 1'b0, 8'h00, 8'h00);

        // Reset and start together: reset wins.
        a8     = 8'h00;
        b8     = 8'hFF;
        start8 = 1'b1;
        rst    = 1'b1;
        step();
        rst    = 1'b0;
        start8 = 1'b0;
        check("rst_start.busy", int'(busy8), 0);
        check("rst_start.gt", int'(gt8), 0);
        step();
        check("rst_start.busy2", int'(busy8), 0);
        check("rst_start.done", int'(done8), 0);

        // Exhaustive 4-bit sweep, back-to-back requests.
        for (int ia = 0; ia < 16; ia++) begin
            for (int ib = 0; ib < 16; ib++) begin
                int n;
                int exp_lat;
                a4      = 4'(ia);
                b4      = 4'(ib);
                start4  = 1'b1;
                exp_lat = (a4[3:2] != b4[3:2]) ? 2 : 3;
                n = 0;
                while (!in_ready4 && n < 10) begin
                    step();
                    n++;
                end
                check("x4.ready_wait", int'(n < 10), 1);
                step();
                start4 = 1'b0;
                n      = 1;
                while (!done4 && n < 10) begin
                    step();
                    n++;
                end
                check("x4.latency", n, exp_lat);
                check("x4.gt", int'(gt4), int'(ia > ib));
                check("x4.eq", int'(eq4), int'(ia == ib));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
